// File: rtl/riscv_ctrl_alu.sv
// Single-cycle RV32I control slice: main decoder, ALU decoder, ALU and branch resolution.
// All outputs are registered together so a given cycle's outputs describe one instruction.
module riscv_ctrl_alu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      op,
   input  logic [2:0]      funct3,
   input  logic            funct7,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic [XLEN-1:0] alu_result,
   output logic            Zero,
   output logic            PCSrc,
   output logic            MemWrite,
   output logic            ALUSrc,
   output logic            RegWrite,
   output logic [1:0]      ImmSrc,
   output logic [1:0]      ResultSrc,
   output logic [2:0]      ALUControl
);

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpReg   = 7'b0110011;
   localparam logic [6:0] OpImm   = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluXor = 3'b100;
   localparam logic [2:0] AluSlt = 3'b101;
   localparam logic [2:0] AluSll = 3'b110;
   localparam logic [2:0] AluSrl = 3'b111;

   logic            reg_write_d, alu_src_d, mem_write_d, branch_d, jump_d;
   logic [1:0]      imm_src_d, result_src_d, alu_op_d;
   logic [2:0]      alu_ctrl_d;
   logic [XLEN-1:0] alu_res_d;
   logic            zero_d, pc_src_d;
   logic            slt_lt;

   // Main decoder
   always_comb begin
      reg_write_d  = 1'b0;
      imm_src_d    = 2'b00;
      alu_src_d    = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
      branch_d     = 1'b0;
      alu_op_d     = 2'b00;
      jump_d       = 1'b0;
      case (op)
         OpLoad: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 1'b1;
            result_src_d = 2'b01;
         end
         OpStore: begin
            imm_src_d   = 2'b01;
            alu_src_d   = 1'b1;
            mem_write_d = 1'b1;
         end
         OpReg: begin
            reg_write_d = 1'b1;
            alu_op_d    = 2'b10;
         end
         OpImm: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_op_d    = 2'b10;
         end
         OpBeq: begin
            imm_src_d = 2'b10;
            branch_d  = 1'b1;
            alu_op_d  = 2'b01;
         end
         OpJal: begin
            reg_write_d  = 1'b1;
            imm_src_d    = 2'b11;
            result_src_d = 2'b10;
            jump_d       = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder; op[5] separates R-type from I-ALU so addi never subtracts
   always_comb begin
      alu_ctrl_d = AluAdd;
      unique case (alu_op_d)
         2'b00: alu_ctrl_d = AluAdd;
         2'b01: alu_ctrl_d = AluSub;
         default: begin
            case (funct3)
               3'b000:  alu_ctrl_d = (op[5] & funct7) ? AluSub : AluAdd;
               3'b001:  alu_ctrl_d = AluSll;
               3'b010:  alu_ctrl_d = AluSlt;
               3'b100:  alu_ctrl_d = AluXor;
               3'b101:  alu_ctrl_d = AluSrl;
               3'b110:  alu_ctrl_d = AluOr;
               3'b111:  alu_ctrl_d = AluAnd;
               default: alu_ctrl_d = AluAdd;
            endcase
         end
      endcase
   end

   assign slt_lt = $signed(src_a) < $signed(src_b);

   always_comb begin
      alu_res_d = '0;
      case (alu_ctrl_d)
         AluAdd:  alu_res_d = src_a + src_b;
         AluSub:  alu_res_d = src_a - src_b;
         AluAnd:  alu_res_d = src_a & src_b;
         AluOr:   alu_res_d = src_a | src_b;
         AluXor:  alu_res_d = src_a ^ src_b;
         AluSlt:  alu_res_d = {{(XLEN-1){1'b0}}, slt_lt};
         AluSll:  alu_res_d = src_a << src_b[4:0];
         AluSrl:  alu_res_d = src_a >> src_b[4:0];
         default: alu_res_d = '0;
      endcase
   end

   assign zero_d   = (alu_res_d == '0);
   assign pc_src_d = (branch_d & zero_d) | jump_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result <= '0;
         Zero       <= 1'b0;
         PCSrc      <= 1'b0;
         MemWrite   <= 1'b0;
         ALUSrc     <= 1'b0;
         RegWrite   <= 1'b0;
         ImmSrc     <= 2'b00;
         ResultSrc  <= 2'b00;
         ALUControl <= 3'b000;
      end else begin
         alu_result <= alu_res_d;
         Zero       <= zero_d;
         PCSrc      <= pc_src_d;
         MemWrite   <= mem_write_d;
         ALUSrc     <= alu_src_d;
         RegWrite   <= reg_write_d;
         ImmSrc     <= imm_src_d;
         ResultSrc  <= result_src_d;
         ALUControl <= alu_ctrl_d;
      end
   end

endmodule

// File: tb/tb_riscv_ctrl_alu.sv
// Self-checking bench for riscv_ctrl_alu: reference model feeds a scoreboard queue,
// entries are popped and compared one cycle after each instruction is applied.
module tb_riscv_ctrl_alu;

   logic        clk;
   logic        rst_n;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] src_a, src_b;
   logic [31:0] alu_result;
   logic        Zero, PCSrc, MemWrite, ALUSrc, RegWrite;
   logic [1:0]  ImmSrc, ResultSrc;
   logic [2:0]  ALUControl;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        pcsrc;
      logic        memwrite;
      logic        alusrc;
      logic        regwrite;
      logic [1:0]  immsrc;
      logic [1:0]  resultsrc;
      logic [2:0]  aluctl;
   } exp_t;

   exp_t exp_q[$];

   riscv_ctrl_alu #(.XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct3     (funct3),
      .funct7     (funct7),
      .src_a      (src_a),
      .src_b      (src_b),
      .alu_result (alu_result),
      .Zero       (Zero),
      .PCSrc      (PCSrc),
      .MemWrite   (MemWrite),
      .ALUSrc     (ALUSrc),
      .RegWrite   (RegWrite),
      .ImmSrc     (ImmSrc),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t       e;
      logic       branch, jump;
      logic [1:0] aluop;
      e      = '0;
      branch = 1'b0;
      jump   = 1'b0;
      aluop  = 2'b00;
      case (o)
         7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'b01; end
         7'b0100011: begin e.immsrc = 2'b01; e.alusrc = 1; e.memwrite = 1; end
         7'b0110011: begin e.regwrite = 1; aluop = 2'b10; end
         7'b0010011: begin e.regwrite = 1; e.alusrc = 1; aluop = 2'b10; end
         7'b1100011: begin e.immsrc = 2'b10; branch = 1; aluop = 2'b01; end
         7'b1101111: begin e.regwrite = 1; e.immsrc = 2'b11; e.resultsrc = 2'b10; jump = 1; end
         default: ;
      endcase
      if (aluop == 2'b00)      e.aluctl = 3'b000;
      else if (aluop == 2'b01) e.aluctl = 3'b001;
      else begin
         case (f3)
            3'b000:  e.aluctl = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b001:  e.aluctl = 3'b110;
            3'b010:  e.aluctl = 3'b101;
            3'b100:  e.aluctl = 3'b100;
            3'b101:  e.aluctl = 3'b111;
            3'b110:  e.aluctl = 3'b011;
            3'b111:  e.aluctl = 3'b010;
            default: e.aluctl = 3'b000;
         endcase
      end
      case (e.aluctl)
         3'b000: e.res = a + b;
         3'b001: e.res = a - b;
         3'b010: e.res = a & b;
         3'b011: e.res = a | b;
         3'b100: e.res = a ^ b;
         3'b101: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         3'b110: e.res = a << b[4:0];
         default: e.res = a >> b[4:0];
      endcase
      e.zero  = (e.res == 32'd0);
      e.pcsrc = (branch & e.zero) | jump;
      return e;
   endfunction

   task automatic compare_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, ".res"},       alu_result,         e.res);
         check_eq({tag, ".zero"},      {31'd0, Zero},      {31'd0, e.zero});
         check_eq({tag, ".pcsrc"},     {31'd0, PCSrc},     {31'd0, e.pcsrc});
         check_eq({tag, ".memwrite"},  {31'd0, MemWrite},  {31'd0, e.memwrite});
         check_eq({tag, ".alusrc"},    {31'd0, ALUSrc},    {31'd0, e.alusrc});
         check_eq({tag, ".regwrite"},  {31'd0, RegWrite},  {31'd0, e.regwrite});
         check_eq({tag, ".immsrc"},    {30'd0, ImmSrc},    {30'd0, e.immsrc});
         check_eq({tag, ".resultsrc"}, {30'd0, ResultSrc}, {30'd0, e.resultsrc});
         check_eq({tag, ".aluctl"},    {29'd0, ALUControl}, {29'd0, e.aluctl});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".res"}, alu_result, 32'd0);
      check_eq({tag, ".flags"}, {26'd0, Zero, PCSrc, MemWrite, ALUSrc, RegWrite, 1'b0}, 32'd0);
      check_eq({tag, ".fields"}, {25'd0, ImmSrc, ResultSrc, ALUControl}, 32'd0);
   endtask

   task automatic apply(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op     = o;
      funct3 = f3;
      funct7 = f7;
      src_a  = a;
      src_b  = b;
      exp_q.push_back(model(o, f3, f7, a, b));
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   logic [6:0] op_tab [7];

   initial begin
      op_tab[0] = 7'b0000011;
      op_tab[1] = 7'b0100011;
      op_tab[2] = 7'b0110011;
      op_tab[3] = 7'b0010011;
      op_tab[4] = 7'b1100011;
      op_tab[5] = 7'b1101111;
      op_tab[6] = 7'b1110011;

      rst_n  = 1'b0;
      op     = '0;
      funct3 = '0;
      funct7 = 1'b0;
      src_a  = '0;
      src_b  = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      apply("lw",      7'b0000011, 3'b010, 1'b0, 32'h100, 32'h8);
      apply("sw",      7'b0100011, 3'b010, 1'b0, 32'h200, 32'h4);
      apply("sub",     7'b0110011, 3'b000, 1'b1, 32'd7, 32'd5);
      check_eq("sub.spec_res", alu_result, 32'd2);
      apply("beq_t",   7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9);
      check_eq("beq_t.spec_pcsrc", {31'd0, PCSrc}, 32'd1);
      apply("beq_nt",  7'b1100011, 3'b000, 1'b0, 32'd9, 32'd8);
      check_eq("beq_nt.spec_pcsrc", {31'd0, PCSrc}, 32'd0);
      apply("addi_f7", 7'b0010011, 3'b000, 1'b1, 32'd10, 32'd3);
      check_eq("addi_f7.spec_ctl", {29'd0, ALUControl}, 32'd0);
      apply("slt",     7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check_eq("slt.spec_res", alu_result, 32'd1);
      apply("sltu_no", 7'b0110011, 3'b010, 1'b0, 32'd1, 32'hFFFF_FFFF);
      apply("sll",     7'b0110011, 3'b001, 1'b0, 32'h8000_0001, 32'hFFFF_FFE4);
      apply("srl",     7'b0110011, 3'b101, 1'b1, 32'h8000_0000, 32'd31);
      apply("xor",     7'b0110011, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      apply("or",      7'b0010011, 3'b110, 1'b0, 32'h1234_0000, 32'h0000_5678);
      apply("and",     7'b0110011, 3'b111, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
      apply("f3_011",  7'b0110011, 3'b011, 1'b0, 32'd4, 32'd6);
      apply("add_wrap", 7'b0110011, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1);
      apply("illegal", 7'b1110011, 3'b000, 1'b1, 32'd5, 32'd5);
      apply("jal",     7'b1101111, 3'b000, 1'b0, 32'd3, 32'd4);
      check_eq("jal.spec_pcsrc", {31'd0, PCSrc}, 32'd1);

      // Asynchronous reset away from any clock edge must clear outputs immediately
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 60; i++) begin
         logic [6:0]  o;
         logic [31:0] a, b;
         o = op_tab[$urandom_range(0, 6)];
         a = $urandom;
         b = ($urandom_range(0, 1) == 0) ? a : $urandom;
         apply($sformatf("rnd%0d", i), o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               a, b);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
